// File: rtl/clock_manager_seq.sv
// PLL lock qualifier and reset sequencer for the 48 MHz domain, plus NUM_CH
// fractional clock-enable strobes generated from per-channel phase accumulators.
module clock_manager_seq #(
    parameter int NUM_CH        = 4,
    parameter int ACC_W         = 24,
    parameter int STABLE_CYCLES = 4800,
    parameter int LOSS_CNT_W    = 8
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic                    pll_lock,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*ACC_W-1:0] ch_incr,
    output logic                    rst_out,
    output logic                    ready,
    output logic [NUM_CH-1:0]       ce_out,
    output logic [LOSS_CNT_W-1:0]   loss_count
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);

    localparam logic [1:0] S_WAIT_LOCK = 2'd0;
    localparam logic [1:0] S_STABLE    = 2'd1;
    localparam logic [1:0] S_RUN       = 2'd2;

    logic                  sync1_q, sync2_q;
    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;
    logic                  rst_out_q;
    logic                  run_d;
    logic [ACC_W-1:0]      acc_q [NUM_CH];
    logic [ACC_W-1:0]      acc_d [NUM_CH];
    logic [ACC_W:0]        sum   [NUM_CH];
    logic [NUM_CH-1:0]     ce_q, ce_d;
    logic                  lock_s;

    assign lock_s = sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;
        case (state_q)
            S_WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s) state_d = S_STABLE;
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                    if (loss_q != '1) loss_d = loss_q + LOSS_CNT_W'(1);
                end
            end
            default: begin
                state_d = S_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    assign run_d = (state_d == S_RUN);

    // Channels advance only while already ready and staying in RUN, so strobes
    // are suppressed on the same edge that re-asserts rst_out.
    always_comb begin
        ce_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sum[i]   = {1'b0, acc_q[i]} + {1'b0, ch_incr[i*ACC_W +: ACC_W]};
            acc_d[i] = '0;
            if (!rst_out_q && run_d && ch_en[i]) begin
                acc_d[i] = sum[i][ACC_W-1:0];
                ce_d[i]  = sum[i][ACC_W];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= S_WAIT_LOCK;
            cnt_q     <= '0;
            loss_q    <= '0;
            rst_out_q <= 1'b1;
            ce_q      <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
        end else begin
            sync1_q   <= pll_lock;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            loss_q    <= loss_d;
            rst_out_q <= !run_d;
            ce_q      <= ce_d;
            for (int unsigned i = 0; i < NUM_CH; i++) acc_q[i] <= acc_d[i];
        end
    end

    assign rst_out    = rst_out_q;
    assign ready      = !rst_out_q;
    assign ce_out     = ce_q;
    assign loss_count = loss_q;

endmodule

// File: tb/tb_clock_manager_seq.sv
// Bench for clock_manager_seq: cycle-level reference model feeding a scoreboard,
// plus directed latency, strobe-pattern, lock-loss and async-reset scenarios.
module tb_clock_manager_seq;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        pll_lock;
    logic [3:0]  ch_en;
    logic [31:0] ch_incr;
    logic        rst_out;
    logic        ready;
    logic [3:0]  ce_out;
    logic [1:0]  loss_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb_q[$];

    logic       m_s1, m_s2;
    int         m_state;
    int         m_cnt;
    logic [7:0] m_acc [4];
    logic [3:0] m_ce;
    logic       m_rst;
    logic [1:0] m_loss;

    clock_manager_seq #(
        .NUM_CH(4),
        .ACC_W(8),
        .STABLE_CYCLES(16),
        .LOSS_CNT_W(2)
    ) dut (
        .clk_in(clk_in),
        .rst(rst),
        .pll_lock(pll_lock),
        .ch_en(ch_en),
        .ch_incr(ch_incr),
        .rst_out(rst_out),
        .ready(ready),
        .ce_out(ce_out),
        .loss_count(loss_count)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One clock: advance the model with the inputs present at this edge,
    // queue its outputs, then compare them to the DUT after the edge.
    task automatic cyc(input string tag);
        logic [7:0] exp_v;
        logic [8:0] sum;
        int         ns;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_state = 0; m_cnt = 0;
            for (int c = 0; c < 4; c++) m_acc[c] = '0;
            m_ce = '0; m_rst = 1'b1; m_loss = '0;
        end else begin
            ns = m_state;
            case (m_state)
                0: begin
                    m_cnt = 0;
                    if (m_s2) ns = 1;
                end
                1: begin
                    if (!m_s2) begin ns = 0; m_cnt = 0; end
                    else if (m_cnt == 15) begin ns = 2; m_cnt = 0; end
                    else m_cnt++;
                end
                default: begin
                    if (!m_s2) begin
                        ns = 0; m_cnt = 0;
                        if (m_loss != 2'd3) m_loss = m_loss + 2'd1;
                    end
                end
            endcase
            for (int c = 0; c < 4; c++) begin
                if (!m_rst && ns == 2 && ch_en[c]) begin
                    sum = {1'b0, m_acc[c]} + {1'b0, ch_incr[c*8 +: 8]};
                    m_acc[c] = sum[7:0];
                    m_ce[c]  = sum[8];
                end else begin
                    m_acc[c] = '0;
                    m_ce[c]  = 1'b0;
                end
            end
            m_rst   = (ns != 2);
            m_state = ns;
            m_s2    = m_s1;
            m_s1    = pll_lock;
        end
        sb_q.push_back({m_rst, !m_rst, m_ce, m_loss});
        @(posedge clk_in);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if (rst_out !== exp_v[7]) begin
            errors++;
            $display("FAIL %s rst_out: got %b want %b", tag, rst_out, exp_v[7]);
        end
        checks++;
        if (ready !== exp_v[6]) begin
            errors++;
            $display("FAIL %s ready: got %b want %b", tag, ready, exp_v[6]);
        end
        checks++;
        if (ce_out !== exp_v[5:2]) begin
            errors++;
            $display("FAIL %s ce_out: got %b want %b", tag, ce_out, exp_v[5:2]);
        end
        checks++;
        if (loss_count !== exp_v[1:0]) begin
            errors++;
            $display("FAIL %s loss_count: got %0d want %0d", tag, loss_count, exp_v[1:0]);
        end
    endtask

    // Cycles until rst_out first reads 0, counted from the caller's last edge; -1 if never.
    task automatic wait_release(input string tag, output int n);
        n = -1;
        for (int k = 1; k <= 60; k++) begin
            cyc(tag);
            if (rst_out === 1'b0) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pll_lock = 1'b0; ch_en = '0; ch_incr = '0;
        cyc("reset_hold");
        cyc("reset_hold");
        rst = 1'b0;
        repeat (20) cyc("reset_nolock");
        checks++;
        if ({rst_out, ready, ce_out, loss_count} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_idle: got %b want %b", {rst_out, ready, ce_out, loss_count}, 8'b1000_0000);
        end
    endtask

    task automatic test_lock_release();
        int n;
        pll_lock = 1'b1;
        wait_release("release", n);
        checks++;
        if (n !== 19) begin
            errors++;
            $display("FAIL release_latency: got %0d want 19", n);
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready: got %b want 1", ready);
        end
    endtask

    task automatic test_glitch();
        int n;
        pll_lock = 1'b0;
        rst = 1'b1;
        cyc("glitch_rst");
        rst = 1'b0;
        cyc("glitch_idle");
        pll_lock = 1'b1;
        n = -1;
        for (int k = 1; k <= 60; k++) begin
            cyc("glitch");
            if (k == 12) pll_lock = 1'b0;
            if (k == 13) pll_lock = 1'b1;
            if (rst_out === 1'b0) begin
                n = k;
                break;
            end
        end
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL glitch_release: got %0d want 32", n);
        end
        checks++;
        if (loss_count !== 2'd0) begin
            errors++;
            $display("FAIL glitch_loss: got %0d want 0", loss_count);
        end
    endtask

    task automatic test_channels();
        logic [3:0] want;
        ch_incr = {8'd128, 8'd255, 8'd0, 8'd64};
        ch_en = 4'b0000;
        cyc("ch_idle");
        ch_en = 4'b0111;
        for (int k = 1; k <= 16; k++) begin
            cyc("ch_run");
            want = {1'b0, (k >= 2), 1'b0, (k % 4 == 0)};
            checks++;
            if (ce_out !== want) begin
                errors++;
                $display("FAIL ch_pattern k=%0d: got %b want %b", k, ce_out, want);
            end
        end
        ch_incr[7:0] = 8'd128;
        ch_en = 4'b1111;
        repeat (10) cyc("ch_live_incr");
    endtask

    task automatic test_lock_loss();
        int n;
        pll_lock = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            cyc("loss_drop");
            if (k == 2) begin
                checks++;
                if (rst_out !== 1'b0) begin
                    errors++;
                    $display("FAIL loss_early: got rst_out=%b want 0", rst_out);
                end
            end
        end
        checks++;
        if ({rst_out, ce_out, loss_count} !== 7'b1_0000_01) begin
            errors++;
            $display("FAIL loss_assert: got %b want %b", {rst_out, ce_out, loss_count}, 7'b1_0000_01);
        end
        ch_incr[7:0] = 8'd64;
        ch_en = 4'b0001;
        pll_lock = 1'b1;
        wait_release("relock", n);
        checks++;
        if (n < 0) begin
            errors++;
            $display("FAIL relock: got no release want release");
        end
        for (int k = 1; k <= 4; k++) begin
            cyc("relock_phase");
            checks++;
            if (ce_out[0] !== (k == 4)) begin
                errors++;
                $display("FAIL relock_phase k=%0d: got %b want %b", k, ce_out[0], (k == 4));
            end
        end
        for (int r = 0; r < 4; r++) begin
            pll_lock = 1'b0;
            repeat (4) cyc("sat_drop");
            pll_lock = 1'b1;
            wait_release("sat_relock", n);
        end
        checks++;
        if (loss_count !== 2'd3) begin
            errors++;
            $display("FAIL loss_saturate: got %0d want 3", loss_count);
        end
    endtask

    task automatic test_async_reset();
        realtime t0;
        ch_en = 4'b1111;
        ch_incr = {8'd255, 8'd255, 8'd255, 8'd255};
        repeat (3) cyc("async_pre");
        t0 = $realtime;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({rst_out, ready, ce_out, loss_count} !== 8'b1000_0000 || ($realtime - t0) > 5.0) begin
            errors++;
            $display("FAIL async_reset: got %b want %b", {rst_out, ready, ce_out, loss_count}, 8'b1000_0000);
        end
        cyc("async_hold");
        rst = 1'b0;
        pll_lock = 1'b0;
        repeat (5) cyc("async_after");
    endtask

    initial begin
        test_reset();
        test_lock_release();
        test_glitch();
        test_channels();
        test_lock_loss();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
